store_to_fetch_arbiter: RTL and testbench

Shares the single-slot store-to-fetch mailbox between up to NUM_REQ producers: the store lanes, the exception unit and the redirect logic. Each producer gets a one-entry hold register. A round-robin arbiter moves one held packet at a time into the mailbox slot whenever the fetch stage has consumed the previous one. The block sits between the store/exception stages and fetch, and replaces direct `send` calls on the bus. The slot therefore can never be double-written.

---
 rtl/store_to_fetch_arbiter.sv | 132 +++++++++++++
 tb/tb_store_to_fetch_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_to_fetch_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ one-deep hold registers into the
// single store-to-fetch mailbox slot; the slot is only loaded when empty or popping.
module store_to_fetch_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PKT_W   = 64,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*PKT_W-1:0]   req_pkt,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush,
  output logic                       can_receive,
  output logic [PKT_W-1:0]           data,
  output logic [SRC_W-1:0]           data_src,
  input  logic                       fetch_recv,
  output logic                       err_underflow
);

  localparam int unsigned LAST_IDX = NUM_REQ - 1;

  // Per-requester hold registers
  logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
  logic [PKT_W-1:0]   hold_pkt_q [NUM_REQ];
  logic [PKT_W-1:0]   hold_pkt_d [NUM_REQ];

  // Mailbox slot and arbitration state
  logic               slot_full_q, slot_full_d;
  logic [PKT_W-1:0]   slot_pkt_q, slot_pkt_d;
  logic [SRC_W-1:0]   slot_src_q, slot_src_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               err_q, err_d;

  // Arbitration scratch
  logic               found;
  logic [SRC_W-1:0]   win;
  logic [SRC_W-1:0]   idx_s;
  int unsigned        idx;
  logic               pop;
  logic               slot_free;

  assign req_ready     = ~hold_valid_q & {NUM_REQ{~flush}};
  assign can_receive   = slot_full_q;
  assign data          = slot_pkt_q;
  assign data_src      = slot_src_q;
  assign err_underflow = err_q;

  // Winner search starting at rr_ptr, wrapping by explicit compare so
  // non-power-of-two NUM_REQ never visits an out-of-range index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_s = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx > LAST_IDX) begin
        idx = idx - NUM_REQ;
      end
      idx_s = SRC_W'(idx);
      if (!found && hold_valid_q[idx_s]) begin
        found = 1'b1;
        win   = idx_s;
      end
    end
  end

  // Next-state: underflow, flush, load/pop, then independent accepts
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_pkt_d   = hold_pkt_q;
    slot_full_d  = slot_full_q;
    slot_pkt_d   = slot_pkt_q;
    slot_src_d   = slot_src_q;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q;

    pop       = fetch_recv && slot_full_q;
    slot_free = !slot_full_q || pop;

    if (fetch_recv && !slot_full_q) begin
      err_d = 1'b1;
    end

    if (flush) begin
      hold_valid_d = '0;
      slot_full_d  = 1'b0;
    end else begin
      if (slot_free && found) begin
        slot_pkt_d        = hold_pkt_q[win];
        slot_src_d        = win;
        slot_full_d       = 1'b1;
        hold_valid_d[win] = 1'b0;
        rr_ptr_d          = (win == SRC_W'(LAST_IDX)) ? '0 : win + 1'b1;
      end else if (pop) begin
        slot_full_d = 1'b0;
      end

      // A requester being loaded this cycle had req_ready low, so no conflict
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_pkt_d[i]   = req_pkt[i*PKT_W +: PKT_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hold_pkt_q[i] <= '0;
      end
      slot_full_q <= 1'b0;
      slot_pkt_q  <= '0;
      slot_src_q  <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_pkt_q   <= hold_pkt_d;
      slot_full_q  <= slot_full_d;
      slot_pkt_q   <= slot_pkt_d;
      slot_src_q   <= slot_src_d;
      rr_ptr_q     <= rr_ptr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_store_to_fetch_arbiter.sv
// Directed bench for store_to_fetch_arbiter: a 4-requester instance for most
// scenarios and a 3-requester instance for non-power-of-two wrap.
module tb_store_to_fetch_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]   rv;
  logic [255:0] rp;
  logic [3:0]   rr;
  logic         fl;
  logic         cr;
  logic [63:0]  dt;
  logic [1:0]   ds;
  logic         fr;
  logic         eu;

  logic [2:0]   rv3;
  logic [191:0] rp3;
  logic [2:0]   rr3;
  logic         fl3;
  logic         cr3;
  logic [63:0]  dt3;
  logic [1:0]   ds3;
  logic         fr3;
  logic         eu3;

  int checks = 0;
  int errors = 0;

  store_to_fetch_arbiter #(.NUM_REQ(4), .PKT_W(64)) dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_pkt(rp), .req_ready(rr),
    .flush(fl), .can_receive(cr), .data(dt), .data_src(ds),
    .fetch_recv(fr), .err_underflow(eu)
  );

  store_to_fetch_arbiter #(.NUM_REQ(3), .PKT_W(64)) dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_pkt(rp3), .req_ready(rr3),
    .flush(fl3), .can_receive(cr3), .data(dt3), .data_src(ds3),
    .fetch_recv(fr3), .err_underflow(eu3)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rv = '0; rp = '0; fl = 1'b0; fr = 1'b0;
    rv3 = '0; rp3 = '0; fl3 = 1'b0; fr3 = 1'b0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL reset_cr got %0b exp 0", cr); end
    checks++; if (dt !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", dt); end
    checks++; if (ds !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", ds); end
    checks++; if (rr !== 4'hF) begin errors++; $display("FAIL reset_ready got %b exp 1111", rr); end
    checks++; if (eu !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", eu); end
    checks++; if (cr3 !== 1'b0 || rr3 !== 3'b111) begin errors++; $display("FAIL reset3 got cr=%0b rdy=%b exp 0/111", cr3, rr3); end
  endtask

  task automatic test_single();
    rv = 4'b0100; rp[2*64 +: 64] = 64'hA5;
    tick();
    rv = '0;
    #1;
    checks++; if (rr !== 4'b1011) begin errors++; $display("FAIL single_ready_low got %b exp 1011", rr); end
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL single_cr_early got %0b exp 0", cr); end
    tick();
    checks++; if (cr !== 1'b1) begin errors++; $display("FAIL single_cr got %0b exp 1", cr); end
    checks++; if (dt !== 64'hA5) begin errors++; $display("FAIL single_data got %h exp a5", dt); end
    checks++; if (ds !== 2'd2) begin errors++; $display("FAIL single_src got %0d exp 2", ds); end
    checks++; if (rr !== 4'hF) begin errors++; $display("FAIL single_ready_back got %b exp 1111", rr); end
    // rr_ptr is now 3: with 0 and 3 both held, 3 must win first
    rv = 4'b1001; rp[0 +: 64] = 64'h10; rp[3*64 +: 64] = 64'h13;
    tick();
    rv = '0; fr = 1'b1;
    tick();
    checks++; if (dt !== 64'h13 || ds !== 2'd3) begin errors++; $display("FAIL single_rrptr3 got data=%h src=%0d exp 13/3", dt, ds); end
    tick();
    checks++; if (dt !== 64'h10 || ds !== 2'd0) begin errors++; $display("FAIL single_wrap0 got data=%h src=%0d exp 10/0", dt, ds); end
    tick();
    fr = 1'b0;
    #1;
    checks++; if (cr !== 1'b0 || eu !== 1'b0) begin errors++; $display("FAIL single_drain got cr=%0b err=%0b exp 0/0", cr, eu); end
  endtask

  task automatic test_blocking();
    rv = 4'b0010; rp[64 +: 64] = 64'h21;
    tick();
    rv = '0;
    tick();
    checks++; if (cr !== 1'b1 || dt !== 64'h21) begin errors++; $display("FAIL block_fill got cr=%0b data=%h exp 1/21", cr, dt); end
    rv = 4'b0010; rp[64 +: 64] = 64'h22;
    #1;
    checks++; if (rr[1] !== 1'b1) begin errors++; $display("FAIL block_first_ready got %0b exp 1", rr[1]); end
    tick();
    rp[64 +: 64] = 64'h23;
    #1;
    checks++; if (rr[1] !== 1'b0) begin errors++; $display("FAIL block_second_stall got %0b exp 0", rr[1]); end
    tick();
    checks++; if (rr[1] !== 1'b0 || dt !== 64'h21 || cr !== 1'b1) begin errors++; $display("FAIL block_hold got rdy=%0b data=%h cr=%0b exp 0/21/1", rr[1], dt, cr); end
    rv = '0; fr = 1'b1;
    tick();
    fr = 1'b0;
    #1;
    checks++; if (dt !== 64'h22 || ds !== 2'd1 || cr !== 1'b1) begin errors++; $display("FAIL block_reload got data=%h src=%0d cr=%0b exp 22/1/1", dt, ds, cr); end
    fr = 1'b1;
    tick();
    fr = 1'b0;
    #1;
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL block_drain got %0b exp 0", cr); end
  endtask

  task automatic test_underflow();
    fr = 1'b1;
    tick();
    fr = 1'b0;
    #1;
    checks++; if (eu !== 1'b1) begin errors++; $display("FAIL under_set got %0b exp 1", eu); end
    checks++; if (cr !== 1'b0 || dt !== 64'h22) begin errors++; $display("FAIL under_slot got cr=%0b data=%h exp 0/22", cr, dt); end
    tick();
    tick();
    checks++; if (eu !== 1'b1) begin errors++; $display("FAIL under_sticky got %0b exp 1", eu); end
    // Reset mid-operation with a packet held must discard it
    rv = 4'b0100; rp[2*64 +: 64] = 64'hC2;
    tick();
    rv = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (eu !== 1'b0 || cr !== 1'b0 || rr !== 4'hF) begin errors++; $display("FAIL under_reset got err=%0b cr=%0b rdy=%b exp 0/0/1111", eu, cr, rr); end
    tick();
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL reset_discard got %0b exp 0", cr); end
  endtask

  task automatic test_flush();
    rv = 4'b1001; rp[0 +: 64] = 64'h30; rp[3*64 +: 64] = 64'h33;
    tick();
    rv = '0;
    tick();
    rv = 4'b0001; rp[0 +: 64] = 64'h40;
    tick();
    checks++; if (cr !== 1'b1 || dt !== 64'h30 || rr !== 4'b0110) begin errors++; $display("FAIL flush_setup got cr=%0b data=%h rdy=%b exp 1/30/0110", cr, dt, rr); end
    fl = 1'b1; rv = 4'b0010; rp[64 +: 64] = 64'h41;
    #1;
    checks++; if (rr !== 4'b0000) begin errors++; $display("FAIL flush_ready_low got %b exp 0000", rr); end
    tick();
    fl = 1'b0; rv = '0;
    #1;
    checks++; if (cr !== 1'b0 || rr !== 4'hF) begin errors++; $display("FAIL flush_clear got cr=%0b rdy=%b exp 0/1111", cr, rr); end
    tick();
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b exp 0", cr); end
    // rr_ptr kept at 1: requester 1 beats requester 0
    rv = 4'b0011; rp[0 +: 64] = 64'h50; rp[64 +: 64] = 64'h51;
    tick();
    rv = '0;
    tick();
    checks++; if (ds !== 2'd1 || dt !== 64'h51) begin errors++; $display("FAIL flush_rrptr got src=%0d data=%h exp 1/51", ds, dt); end
    fr = 1'b1;
    tick();
    checks++; if (ds !== 2'd0 || dt !== 64'h50) begin errors++; $display("FAIL flush_second got src=%0d data=%h exp 0/50", ds, dt); end
    tick();
    fr = 1'b0;
    #1;
    checks++; if (cr !== 1'b0 || eu !== 1'b0) begin errors++; $display("FAIL flush_drain got cr=%0b err=%0b exp 0/0", cr, eu); end
  endtask

  task automatic test_fairness();
    // rr_ptr starts at 1
    rv = 4'hF;
    rp[0 +: 64] = 64'h60; rp[64 +: 64] = 64'h71; rp[128 +: 64] = 64'h72; rp[192 +: 64] = 64'h73;
    tick();
    rv = 4'b0001; rp[0 +: 64] = 64'h61;
    tick();
    fr = 1'b1;
    #1;
    checks++; if (ds !== 2'd1 || dt !== 64'h71) begin errors++; $display("FAIL fair_l1 got src=%0d data=%h exp 1/71", ds, dt); end
    tick();
    checks++; if (ds !== 2'd2 || dt !== 64'h72 || cr !== 1'b1) begin errors++; $display("FAIL fair_l2 got src=%0d data=%h exp 2/72", ds, dt); end
    tick();
    checks++; if (ds !== 2'd3 || dt !== 64'h73 || cr !== 1'b1) begin errors++; $display("FAIL fair_l3 got src=%0d data=%h exp 3/73", ds, dt); end
    tick();
    checks++; if (ds !== 2'd0 || dt !== 64'h60 || cr !== 1'b1) begin errors++; $display("FAIL fair_l4 got src=%0d data=%h exp 0/60", ds, dt); end
    tick();
    rv = '0; fr = 1'b0;
    #1;
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL fair_gap got %0b exp 0", cr); end
    tick();
    checks++; if (cr !== 1'b1 || ds !== 2'd0 || dt !== 64'h61) begin errors++; $display("FAIL fair_reoffer got cr=%0b src=%0d data=%h exp 1/0/61", cr, ds, dt); end
    fr = 1'b1;
    tick();
    fr = 1'b0;
    #1;
    checks++; if (cr !== 1'b0 || eu !== 1'b0) begin errors++; $display("FAIL fair_end got cr=%0b err=%0b exp 0/0", cr, eu); end
  endtask

  task automatic test_rr_wrap3();
    // Load requester 1 so rr_ptr becomes 2, then drain
    rv3 = 3'b010; rp3[64 +: 64] = 64'hA1;
    tick();
    rv3 = '0;
    tick();
    checks++; if (cr3 !== 1'b1 || ds3 !== 2'd1) begin errors++; $display("FAIL wrap_prime got cr=%0b src=%0d exp 1/1", cr3, ds3); end
    fr3 = 1'b1;
    tick();
    fr3 = 1'b0;
    rv3 = 3'b111; rp3[0 +: 64] = 64'hB0; rp3[64 +: 64] = 64'hB1; rp3[128 +: 64] = 64'hB2;
    tick();
    rv3 = '0;
    tick();
    fr3 = 1'b1;
    #1;
    checks++; if (ds3 !== 2'd2 || dt3 !== 64'hB2) begin errors++; $display("FAIL wrap_first got src=%0d data=%h exp 2/b2", ds3, dt3); end
    tick();
    checks++; if (ds3 !== 2'd0 || dt3 !== 64'hB0 || cr3 !== 1'b1) begin errors++; $display("FAIL wrap_second got src=%0d data=%h exp 0/b0", ds3, dt3); end
    tick();
    checks++; if (ds3 !== 2'd1 || dt3 !== 64'hB1 || cr3 !== 1'b1) begin errors++; $display("FAIL wrap_third got src=%0d data=%h exp 1/b1", ds3, dt3); end
    tick();
    fr3 = 1'b0;
    #1;
    checks++; if (cr3 !== 1'b0 || eu3 !== 1'b0) begin errors++; $display("FAIL wrap_end got cr=%0b err=%0b exp 0/0", cr3, eu3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_blocking();
    test_underflow();
    test_flush();
    test_fairness();
    test_rr_wrap3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
